// File: rtl/cmd_arbiter_if.sv
// Command arbiter bus: requester pulses, error status, engine handshake and
// the arbiter's status/drop/abort outputs.
//   slave  : arbiter side (requests/status in, start/flags/pulses out)
//   master : environment side (drives requests/status, observes outputs)
interface cmd_arbiter_if;
    logic       clk_en_p_i;
    logic       drv_req_i;
    logic       drv_busy_rsp_i;
    logic       cmd12_req_i;
    logic       cmd23_req_i;
    logic       cmd_err_i;
    logic       acmd12_err_i;
    logic       eng_ready_i;
    logic       eng_done_i;
    logic       start_o;
    logic [1:0] sel_o;
    logic       busy_o;
    logic       cmd_inhibit_o;
    logic       dat_busy_o;
    logic       cmd12_not_exec_o;
    logic       not_issued_by_cmd12_o;
    logic       cmd23_drop_o;
    logic       abort_o;

    modport slave (
        input  clk_en_p_i, drv_req_i, drv_busy_rsp_i, cmd12_req_i, cmd23_req_i,
               cmd_err_i, acmd12_err_i, eng_ready_i, eng_done_i,
        output start_o, sel_o, busy_o, cmd_inhibit_o, dat_busy_o,
               cmd12_not_exec_o, not_issued_by_cmd12_o, cmd23_drop_o, abort_o
    );

    modport master (
        output clk_en_p_i, drv_req_i, drv_busy_rsp_i, cmd12_req_i, cmd23_req_i,
               cmd_err_i, acmd12_err_i, eng_ready_i, eng_done_i,
        input  start_o, sel_o, busy_o, cmd_inhibit_o, dat_busy_o,
               cmd12_not_exec_o, not_issued_by_cmd12_o, cmd23_drop_o, abort_o
    );
endinterface

// File: rtl/cmd_arbiter.sv
// cmd_arbiter: shares the SD command engine between the host driver, auto-CMD12
// and auto-CMD23. Holds one pending flag per requester, grants by fixed priority
// (CMD12 > CMD23 > driver), drops requests gated by sticky error status, issues
// a start handshake aligned to the SD clock enable, owns Command Inhibit (CMD)
// and DAT-busy, and aborts a command with a strobe-counting watchdog.
// Ports:
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   bus    : cmd_arbiter_if.slave (requests, error status, engine handshake,
//            sel/start/busy, inhibit flags, drop and abort pulses)
// TIMEOUT_STROBES (>= 2): clk_en_p_i strobes allowed in RUN before abort.
module cmd_arbiter #(
    parameter int unsigned TIMEOUT_STROBES = 1024
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    cmd_arbiter_if.slave bus
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_STROBES + 1);

    localparam logic [1:0] SEL_DRV = 2'b00;
    localparam logic [1:0] SEL_C12 = 2'b01;
    localparam logic [1:0] SEL_C23 = 2'b10;

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_STROBES - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_STROBES);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RUN   = 2'b10
    } state_t;

    state_t          state;
    logic [WD_W-1:0] wdog;

    logic pend_drv;
    logic pend_c12;
    logic pend_c23;

    logic       start_q;
    logic [1:0] sel_q;
    logic       busy_q;
    logic       inhibit_q;
    logic       dat_busy_q;
    logic       c12_drop_q;
    logic       drv_drop_q;
    logic       c23_drop_q;
    logic       abort_q;

    // Arbitration: only the highest-priority pending requester is evaluated.
    logic       arb_en;
    logic       win_c12;
    logic       win_c23;
    logic       win_drv;
    logic       drop_c12;
    logic       drop_c23;
    logic       drop_drv;
    logic       grant;
    logic [1:0] win_sel;

    assign arb_en   = (state == IDLE) && bus.eng_ready_i;
    assign win_c12  = arb_en && pend_c12;
    assign win_c23  = arb_en && !pend_c12 && pend_c23;
    assign win_drv  = arb_en && !pend_c12 && !pend_c23 && pend_drv;
    assign drop_c12 = win_c12 && bus.cmd_err_i;
    assign drop_c23 = win_c23 && bus.cmd_err_i;
    assign drop_drv = win_drv && bus.acmd12_err_i;
    assign grant    = (win_c12 && !bus.cmd_err_i) || (win_c23 && !bus.cmd_err_i) ||
                      (win_drv && !bus.acmd12_err_i);
    assign win_sel  = win_c12 ? SEL_C12 : (win_c23 ? SEL_C23 : SEL_DRV);

    // A request for an already pending source, or for the command in flight, is ignored.
    logic active;
    logic take_drv;
    logic take_c12;
    logic take_c23;

    assign active   = (state != IDLE);
    assign take_drv = bus.drv_req_i   && !pend_drv && !(active && sel_q == SEL_DRV);
    assign take_c12 = bus.cmd12_req_i && !pend_c12 && !(active && sel_q == SEL_C12);
    assign take_c23 = bus.cmd23_req_i && !pend_c23 && !(active && sel_q == SEL_C23);

    // Watchdog expiry: this strobe would be the TIMEOUT_STROBES-th one in RUN.
    logic wd_hit;
    logic run_done;
    logic run_abort;
    logic flags_clr;

    assign wd_hit    = bus.clk_en_p_i && (wdog >= WD_LAST);
    assign run_done  = (state == RUN) && bus.eng_done_i;
    assign run_abort = (state == RUN) && !bus.eng_done_i && wd_hit;
    assign flags_clr = ((run_done || run_abort) && (sel_q == SEL_DRV)) || drop_drv;

    // Sequencer, pending flags and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            wdog       <= '0;
            pend_drv   <= 1'b0;
            pend_c12   <= 1'b0;
            pend_c23   <= 1'b0;
            start_q    <= 1'b0;
            sel_q      <= SEL_DRV;
            busy_q     <= 1'b0;
            inhibit_q  <= 1'b0;
            dat_busy_q <= 1'b0;
            c12_drop_q <= 1'b0;
            drv_drop_q <= 1'b0;
            c23_drop_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            c12_drop_q <= drop_c12;
            drv_drop_q <= drop_drv;
            c23_drop_q <= drop_c23;
            abort_q    <= 1'b0;

            // The winner's flag is consumed whether it is granted or dropped.
            pend_drv <= (pend_drv && !win_drv) || take_drv;
            pend_c12 <= (pend_c12 && !win_c12) || take_c12;
            pend_c23 <= (pend_c23 && !win_c23) || take_c23;

            case (state)
                IDLE: begin
                    if (grant) begin
                        state   <= ISSUE;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        sel_q   <= win_sel;
                    end
                end
                ISSUE: begin
                    // Hold start until the engine samples it on an enable strobe.
                    if (bus.clk_en_p_i) begin
                        state   <= RUN;
                        start_q <= 1'b0;
                        wdog    <= '0;
                    end
                end
                RUN: begin
                    if (bus.eng_done_i) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (wd_hit) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        abort_q <= 1'b1;
                    end else if (bus.clk_en_p_i && (wdog != WD_MAX)) begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    start_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase

            // A new driver write takes precedence over a simultaneous clear.
            if (bus.drv_req_i) begin
                inhibit_q <= 1'b1;
            end else if (flags_clr) begin
                inhibit_q <= 1'b0;
            end

            if (bus.drv_req_i && bus.drv_busy_rsp_i) begin
                dat_busy_q <= 1'b1;
            end else if (flags_clr) begin
                dat_busy_q <= 1'b0;
            end
        end
    end

    assign bus.start_o               = start_q;
    assign bus.sel_o                 = sel_q;
    assign bus.busy_o                = busy_q;
    assign bus.cmd_inhibit_o         = inhibit_q;
    assign bus.dat_busy_o            = dat_busy_q;
    assign bus.cmd12_not_exec_o      = c12_drop_q;
    assign bus.not_issued_by_cmd12_o = drv_drop_q;
    assign bus.cmd23_drop_o          = c23_drop_q;
    assign bus.abort_o               = abort_q;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Self-checking bench for cmd_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_cmd_arbiter;

    localparam int unsigned T = 8;

    // Input vector bits: {drv, rsp, c12, c23, cerr, aerr, ready, done, clk_en}
    localparam logic [8:0] I_DRV  = 9'h100;
    localparam logic [8:0] I_RSP  = 9'h080;
    localparam logic [8:0] I_C12  = 9'h040;
    localparam logic [8:0] I_C23  = 9'h020;
    localparam logic [8:0] I_CERR = 9'h010;
    localparam logic [8:0] I_AERR = 9'h008;
    localparam logic [8:0] I_RDY  = 9'h004;
    localparam logic [8:0] I_DONE = 9'h002;
    localparam logic [8:0] I_CE   = 9'h001;
    localparam logic [8:0] B      = I_RDY | I_CE;

    // Output bits: {start, sel[1:0], busy, inhibit, dat_busy, c12ne, nib, c23drop, abort}
    localparam logic [9:0] O_START = 10'h200;
    localparam logic [9:0] S_C23   = 10'h100;
    localparam logic [9:0] S_C12   = 10'h080;
    localparam logic [9:0] O_BUSY  = 10'h040;
    localparam logic [9:0] O_INH   = 10'h020;
    localparam logic [9:0] O_DAT   = 10'h010;
    localparam logic [9:0] O_C12NE = 10'h008;
    localparam logic [9:0] O_NIB   = 10'h004;
    localparam logic [9:0] O_C23D  = 10'h002;
    localparam logic [9:0] O_ABT   = 10'h001;

    typedef struct {
        logic [8:0] in;
        logic [9:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cmd_arbiter_if bus();

    cmd_arbiter #(.TIMEOUT_STROBES(T)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state (source index: 0 driver, 1 CMD12, 2 CMD23)
    bit m_pend[3];
    bit m_iss;
    bit m_run;
    int m_cnt;
    int m_sel;
    bit m_inh;
    bit m_dat;

    function automatic logic [9:0] dut_out();
        return {bus.start_o, bus.sel_o, bus.busy_o, bus.cmd_inhibit_o, bus.dat_busy_o,
                bus.cmd12_not_exec_o, bus.not_issued_by_cmd12_o, bus.cmd23_drop_o,
                bus.abort_o};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [8:0] v);
        bus.drv_req_i      = v[8];
        bus.drv_busy_rsp_i = v[7];
        bus.cmd12_req_i    = v[6];
        bus.cmd23_req_i    = v[5];
        bus.cmd_err_i      = v[4];
        bus.acmd12_err_i   = v[3];
        bus.eng_ready_i    = v[2];
        bus.eng_done_i     = v[1];
        bus.clk_en_p_i     = v[0];
    endtask

    // Advance one clock; outputs are read 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(9'h000);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_start(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (bus.start_o === 1'b1) seen = 1'b1;
        end
        check(nm, 32'(seen), 32'd1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_pend[i] = 1'b0;
        m_iss = 1'b0;
        m_run = 1'b0;
        m_cnt = 0;
        m_sel = 0;
        m_inh = 1'b0;
        m_dat = 1'b0;
    endtask

    // Predicts the outputs after the next edge from the inputs now driven.
    task automatic model_tick(output logic [9:0] exp);
        int  prio[3] = '{1, 2, 0};
        bit  req[3];
        bit  old_pend[3];
        bit  act;
        bit  clr;
        bit  p12, pd, p23, ab;
        bit  gated;
        int  w;
        req[0]   = bus.drv_req_i;
        req[1]   = bus.cmd12_req_i;
        req[2]   = bus.cmd23_req_i;
        old_pend = m_pend;
        act      = m_iss || m_run;
        clr = 1'b0; p12 = 1'b0; pd = 1'b0; p23 = 1'b0; ab = 1'b0;
        w = -1;
        if (!act && bus.eng_ready_i) begin
            for (int i = 0; i < 3; i++) begin
                if (w < 0 && old_pend[prio[i]]) w = prio[i];
            end
        end
        if (w >= 0) begin
            m_pend[w] = 1'b0;
            gated = (w == 0) ? bus.acmd12_err_i : bus.cmd_err_i;
            if (gated) begin
                if (w == 0) begin
                    pd  = 1'b1;
                    clr = 1'b1;
                end else if (w == 1) begin
                    p12 = 1'b1;
                end else begin
                    p23 = 1'b1;
                end
            end else begin
                m_sel = w;
                m_iss = 1'b1;
            end
        end else if (m_iss) begin
            if (bus.clk_en_p_i) begin
                m_iss = 1'b0;
                m_run = 1'b1;
                m_cnt = 0;
            end
        end else if (m_run) begin
            if (bus.eng_done_i) begin
                m_run = 1'b0;
                if (m_sel == 0) clr = 1'b1;
            end else if (bus.clk_en_p_i) begin
                m_cnt++;
                if (m_cnt >= int'(T)) begin
                    ab    = 1'b1;
                    m_run = 1'b0;
                    if (m_sel == 0) clr = 1'b1;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (req[i] && !old_pend[i] && !(act && m_sel == i)) m_pend[i] = 1'b1;
        end
        if (bus.drv_req_i) m_inh = 1'b1;
        else if (clr) m_inh = 1'b0;
        if (bus.drv_req_i && bus.drv_busy_rsp_i) m_dat = 1'b1;
        else if (clr) m_dat = 1'b0;
        exp = {m_iss, 2'(m_sel), m_iss || m_run, m_inh, m_dat, p12, pd, p23, ab};
    endtask

    vec_t tbl[26];

    initial begin
        logic [1:0] exp_sel [3];
        logic [9:0] exp;
        int         starts;

        tbl[0]  = '{B,                      10'h000};
        tbl[1]  = '{B | I_DRV,              O_INH};
        tbl[2]  = '{B,                      O_START | O_BUSY | O_INH};
        tbl[3]  = '{B,                      O_BUSY | O_INH};
        tbl[4]  = '{B,                      O_BUSY | O_INH};
        tbl[5]  = '{B | I_DONE,             10'h000};
        tbl[6]  = '{B | I_C12 | I_CERR,     10'h000};
        tbl[7]  = '{B | I_CERR,             O_C12NE};
        tbl[8]  = '{B,                      10'h000};
        tbl[9]  = '{B,                      10'h000};
        tbl[10] = '{B | I_DRV | I_RSP | I_AERR, O_INH | O_DAT};
        tbl[11] = '{B | I_AERR,             O_NIB};
        tbl[12] = '{B,                      10'h000};
        tbl[13] = '{B | I_C23 | I_CERR,     10'h000};
        tbl[14] = '{B | I_CERR,             O_C23D};
        tbl[15] = '{B,                      10'h000};
        tbl[16] = '{I_CE | I_C23,           10'h000};
        tbl[17] = '{I_CE,                   10'h000};
        tbl[18] = '{B,                      O_START | S_C23 | O_BUSY};
        tbl[19] = '{I_RDY,                  O_START | S_C23 | O_BUSY};
        tbl[20] = '{B,                      S_C23 | O_BUSY};
        tbl[21] = '{B | I_DONE,             S_C23};
        tbl[22] = '{B | I_DRV | I_RSP,      S_C23 | O_INH | O_DAT};
        tbl[23] = '{B,                      O_START | O_BUSY | O_INH | O_DAT};
        tbl[24] = '{B,                      O_BUSY | O_INH | O_DAT};
        tbl[25] = '{B | I_DONE,             10'h000};

        // Reset state
        drive(9'h000);
        rst_n = 1'b0;
        step();
        step();
        check("reset_outputs", 32'(dut_out()), 32'd0);
        rst_n = 1'b1;

        // Directed vector table
        foreach (tbl[i]) begin
            drive(tbl[i].in);
            step();
            check($sformatf("vec%0d", i), 32'(dut_out()), 32'(tbl[i].exp));
        end

        // Simultaneous requests: CMD12, then CMD23, then driver
        do_reset();
        exp_sel[0] = 2'b01;
        exp_sel[1] = 2'b10;
        exp_sel[2] = 2'b00;
        drive(B | I_DRV | I_C12 | I_C23);
        step();
        drive(B);
        for (int g = 0; g < 3; g++) begin
            wait_start($sformatf("prio_start%0d", g));
            check($sformatf("prio_sel%0d", g), 32'(bus.sel_o), 32'(exp_sel[g]));
            step();
            check($sformatf("prio_start_width%0d", g), 32'(bus.start_o), 32'd0);
            step();
            step();
            check($sformatf("prio_busy%0d", g), 32'(bus.busy_o), 32'd1);
            check($sformatf("prio_inh_run%0d", g), 32'(bus.cmd_inhibit_o), 32'd1);
            drive(B | I_DONE);
            step();
            drive(B);
            check($sformatf("prio_done_busy%0d", g), 32'(bus.busy_o), 32'd0);
            check($sformatf("prio_done_inh%0d", g), 32'(bus.cmd_inhibit_o), (g < 2) ? 32'd1 : 32'd0);
        end

        // Slow clock: strobe every 4th cycle, watchdog abort after the 8th RUN strobe
        do_reset();
        for (int k = 0; k <= 40; k++) begin
            drive(I_RDY | ((k % 4 == 3) ? I_CE : 9'h000) | ((k == 0) ? I_DRV : 9'h000));
            step();
            if (k >= 1 && k <= 4)
                check($sformatf("slow_start_k%0d", k), 32'(bus.start_o), (k <= 2) ? 32'd1 : 32'd0);
            if (k >= 3)
                check($sformatf("slow_abort_k%0d", k), 32'(bus.abort_o), (k == 35) ? 32'd1 : 32'd0);
            if (k == 34 || k == 35)
                check($sformatf("slow_inh_k%0d", k), 32'(bus.cmd_inhibit_o), (k < 35) ? 32'd1 : 32'd0);
        end

        // Divide-by-1: done on the expiry strobe wins over abort
        do_reset();
        for (int k = 0; k <= 14; k++) begin
            drive(B | ((k == 0) ? I_DRV : 9'h000) | ((k == 10) ? I_DONE : 9'h000));
            step();
            if (k == 1 || k == 2)
                check($sformatf("fast_start_k%0d", k), 32'(bus.start_o), (k == 1) ? 32'd1 : 32'd0);
            if (k >= 3)
                check($sformatf("expiry_abort_k%0d", k), 32'(bus.abort_o), 32'd0);
            if (k == 9 || k == 10)
                check($sformatf("expiry_busy_k%0d", k), 32'(bus.busy_o), (k == 9) ? 32'd1 : 32'd0);
        end

        // Reset during RUN discards pending auto-command requests
        do_reset();
        drive(B | I_DRV);
        step();
        drive(B);
        step();
        step();
        drive(B | I_C12 | I_C23);
        step();
        drive(B);
        step();
        check("pre_reset_busy", 32'(bus.busy_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'(dut_out()), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        starts = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.start_o === 1'b1) starts++;
        end
        check("no_start_after_reset", 32'(starts), 32'd0);

        // Randomized run against the behavioural model
        do_reset();
        model_reset();
        for (int k = 0; k < 3000; k++) begin
            bus.drv_req_i      = ($urandom_range(0, 14) == 0);
            bus.drv_busy_rsp_i = $urandom_range(0, 1) == 1;
            bus.cmd12_req_i    = ($urandom_range(0, 19) == 0);
            bus.cmd23_req_i    = ($urandom_range(0, 19) == 0);
            bus.cmd_err_i      = ($urandom_range(0, 9) == 0);
            bus.acmd12_err_i   = ($urandom_range(0, 9) == 0);
            bus.eng_ready_i    = ($urandom_range(0, 9) != 0);
            bus.eng_done_i     = ($urandom_range(0, 11) == 0);
            bus.clk_en_p_i     = $urandom_range(0, 1) == 1;
            model_tick(exp);
            step();
            check($sformatf("rand_c%0d", k), 32'(dut_out()), 32'(exp));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
